// File: rtl/control_sequencer_if.sv
// control_sequencer_if: data RAM access handshake.
// Sequencer drives mem_req; RAM answers with mem_ready.
interface control_sequencer_if;
  logic mem_req;
  logic mem_ready;

  modport master (
    output mem_req,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    output mem_ready
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: picks the class decoder, owns state/IR, stalls on RAM.
// Define PERF_CNT_EN to add retired_cnt / stall_cnt outputs.
module control_sequencer #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  control_sequencer_if.master bus,
  input  logic [31:0] instruction,
  input  logic [28:0] cw_r,
  input  logic [28:0] cw_i,
  input  logic [28:0] cw_m,
  input  logic [28:0] cw_b,
  input  logic [1:0]  ns_r,
  input  logic [1:0]  ns_i,
  input  logic [1:0]  ns_m,
  input  logic [1:0]  ns_b,
  input  logic [63:0] k_r,
  input  logic [63:0] k_i,
  input  logic [63:0] k_m,
  input  logic [63:0] k_b,
  output logic [31:0] cur_instr,
  output logic [1:0]  state,
  output logic [28:0] controlWord,
  output logic [63:0] K,
  output logic        illegal,
  output logic        bus_error
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0]  S0  = 2'd0;
  localparam logic [1:0]  S3  = 2'd3;
  localparam logic [28:0] NOP = 29'h0800_0000;
  localparam logic [7:0]  WMAX = 8'(MAX_WAIT);

  logic [31:0] ir;
  logic [7:0]  wait_q;
  logic        hit_i, hit_b, hit_r, hit_m;
  logic        sel_i, sel_b, sel_r, sel_m;
  logic [28:0] sel_cw;
  logic [63:0] sel_k;
  logic [1:0]  sel_ns;
  logic        bad;
  logic        active, access, abort, stall, wrap;
  logic [1:0]  nxt;

  assign cur_instr = (state == S0) ? instruction : ir;

  assign hit_i = cur_instr[28:26] == 3'b100;
  assign hit_b = cur_instr[28:26] == 3'b101;
  assign hit_r = cur_instr[27:25] == 3'b101;
  assign hit_m = cur_instr[27] & ~cur_instr[25];

  assign sel_i = hit_i;
  assign sel_b = hit_b & ~hit_i;
  assign sel_r = hit_r & ~hit_i & ~hit_b;
  assign sel_m = hit_m & ~hit_i & ~hit_b & ~hit_r;

  // route the winning class decoder; undecodable opcodes become a NOP
  always_comb begin
    sel_cw = NOP;
    sel_k  = '0;
    sel_ns = S0;
    bad    = 1'b0;
    unique case (1'b1)
      sel_i: begin
        sel_cw = cw_i;
        sel_k  = k_i;
        sel_ns = ns_i;
      end
      sel_b: begin
        sel_cw = cw_b;
        sel_k  = k_b;
        sel_ns = ns_b;
      end
      sel_r: begin
        sel_cw = cw_r;
        sel_k  = k_r;
        sel_ns = ns_r;
      end
      sel_m: begin
        sel_cw = cw_m;
        sel_k  = k_m;
        sel_ns = ns_m;
      end
      default: begin
        sel_cw = NOP;
        sel_k  = '0;
        sel_ns = S0;
        bad    = 1'b1;
      end
    endcase
  end

  assign active = ~reset;
  assign access = sel_cw[5] | (sel_cw[4:3] == 2'b10);
  assign abort  = active & access & ~bus.mem_ready
                & (wait_q >= WMAX);
  assign stall  = active & access & ~bus.mem_ready & ~abort;
  assign wrap   = (state == S3) & (sel_ns != S0)
                & ~stall & ~abort;

  assign bus.mem_req = active & access;
  assign bus_error   = abort;
  assign illegal     = active & (bad | wrap);
  assign K           = sel_k;

  // mask write-back and PC update while waiting on RAM
  always_comb begin
    controlWord = sel_cw;
    if (abort) begin
      controlWord = '0;
    end else if (stall) begin
      controlWord[28:27] = 2'b00;
      controlWord[6]     = 1'b0;
    end
  end

  // next sequencer state
  always_comb begin
    nxt = sel_ns;
    if (abort || wrap) begin
      nxt = S0;
    end else if (stall) begin
      nxt = state;
    end
  end

  // state, instruction register and RAM wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S0;
      ir     <= '0;
      wait_q <= '0;
    end else begin
      state <= nxt;
      if (state == S0 && !stall) begin
        ir <= instruction;
      end
      if (stall) begin
        wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= '0;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = active & ~stall & (nxt == S0);

  // retired-instruction and stall-cycle counters
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scenarios plus a randomized model run.
// Decoder index: 0 R-ALU, 1 I-ALU, 2 memory, 3 branch.
module tb_control_sequencer;
  localparam int MW = 4;
  localparam logic [28:0] NOP = 29'h0800_0000;
  localparam logic [31:0] RADD = 32'h8B02_0020;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  control_sequencer_if bus();

  logic [31:0] instruction;
  logic [28:0] cw [4];
  logic [1:0]  ns [4];
  logic [63:0] kk [4];
  logic [31:0] cur_instr;
  logic [1:0]  state;
  logic [28:0] controlWord;
  logic [63:0] K;
  logic        illegal;
  logic        bus_error;
`ifdef PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  control_sequencer #(.MAX_WAIT(MW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master),
    .instruction(instruction),
    .cw_r(cw[0]), .cw_i(cw[1]), .cw_m(cw[2]), .cw_b(cw[3]),
    .ns_r(ns[0]), .ns_i(ns[1]), .ns_m(ns[2]), .ns_b(ns[3]),
    .k_r(kk[0]), .k_i(kk[1]), .k_m(kk[2]), .k_b(kk[3]),
    .cur_instr(cur_instr),
    .state(state),
    .controlWord(controlWord),
    .K(K),
    .illegal(illegal),
    .bus_error(bus_error)
`ifdef PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // random decoder outputs that never request RAM, nonzero next state
  task automatic rand_dec();
    for (int i = 0; i < 4; i++) begin
      cw[i] = 29'($urandom);
      cw[i][5] = 1'b0;
      cw[i][4:3] = 2'b01;
      ns[i] = 2'($urandom_range(1, 3));
      kk[i] = {$urandom, $urandom};
    end
  endtask

  function automatic logic [31:0] mem_instr();
    return 32'hF800_0000 | ($urandom & 32'h00FF_FFFF);
  endfunction

  // class rule from the opcode bits, in priority order; -1 = illegal
  function automatic int classify(logic [31:0] c);
    if (c[28:26] == 3'b100) return 1;
    if (c[28:26] == 3'b101) return 3;
    if (c[27:25] == 3'b101) return 0;
    if (c[27] && !c[25]) return 2;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    instruction = 32'h0;
    rand_dec();
    step();
    step();
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want 0", state);
    end
    n_cmp++;
    if ({bus.mem_req, illegal, bus_error} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000",
        {bus.mem_req, illegal, bus_error});
    end
    n_cmp++;
    if (controlWord !== NOP) begin
      n_bad++;
      $display("FAIL reset_cw: got %h want %h", controlWord, NOP);
    end
    reset = 1'b0;
  endtask

  task automatic test_radd();
    instruction = RADD;
    rand_dec();
    ns[0] = 2'd0;
    #1;
    n_cmp++;
    if (controlWord !== cw[0] || K !== kk[0]) begin
      n_bad++;
      $display("FAIL radd_cw: got %h/%h want %h/%h",
        controlWord, K, cw[0], kk[0]);
    end
    n_cmp++;
    if ({bus.mem_req, illegal} !== 2'b00) begin
      n_bad++;
      $display("FAIL radd_flags: got %b want 00",
        {bus.mem_req, illegal});
    end
    step();
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL radd_state: got %0d want 0", state);
    end
  endtask

  task automatic test_multistate();
    logic [31:0] mi;
    mi = mem_instr();
    instruction = mi;
    rand_dec();
    ns[2] = 2'd1;
    #1;
    n_cmp++;
    if (controlWord !== cw[2]) begin
      n_bad++;
      $display("FAIL ms_cw0: got %h want %h", controlWord, cw[2]);
    end
    step();
    instruction = RADD;
    ns[2] = 2'd0;
    #1;
    n_cmp++;
    if (state !== 2'd1 || cur_instr !== mi) begin
      n_bad++;
      $display("FAIL ms_ir: got %0d/%h want 1/%h",
        state, cur_instr, mi);
    end
    n_cmp++;
    if (controlWord !== cw[2]) begin
      n_bad++;
      $display("FAIL ms_cw1: got %h want %h", controlWord, cw[2]);
    end
    step();
    n_cmp++;
    if (state !== 2'd0 || cur_instr !== RADD) begin
      n_bad++;
      $display("FAIL ms_back: got %0d/%h want 0/%h",
        state, cur_instr, RADD);
    end
  endtask

  task automatic test_stall();
    logic [28:0] lw, mk;
    instruction = mem_instr();
    rand_dec();
    lw = cw[2];
    lw[28:27] = 2'b10;
    lw[6] = 1'b1;
    lw[5] = 1'b0;
    lw[4:3] = 2'b10;
    cw[2] = lw;
    mk = lw;
    mk[28:27] = 2'b00;
    mk[6] = 1'b0;
    ns[2] = 2'd1;
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (controlWord !== mk || bus.mem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_cw%0d: got %h/%b want %h/1",
          c, controlWord, bus.mem_req, mk);
      end
      step();
      n_cmp++;
      if (state !== 2'd0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got %0d want 0", c, state);
      end
    end
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (controlWord !== lw) begin
      n_bad++;
      $display("FAIL stall_issue: got %h want %h", controlWord, lw);
    end
    step();
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL stall_adv: got %0d want 1", state);
    end
`ifdef PERF_CNT_EN
    n_cmp++;
    if (stall_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
    ns[2] = 2'd0;
    step();
  endtask

  task automatic test_abort();
    logic [28:0] sw, mk;
    instruction = mem_instr();
    rand_dec();
    sw = cw[2];
    sw[28:27] = 2'b01;
    sw[6] = 1'b1;
    sw[5] = 1'b1;
    cw[2] = sw;
    mk = sw;
    mk[28:27] = 2'b00;
    mk[6] = 1'b0;
    ns[2] = 2'd1;
    bus.mem_ready = 1'b0;
    for (int c = 0; c < MW; c++) begin
      #1;
      n_cmp++;
      if (controlWord !== mk || bus_error !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_wait%0d: got %h/%b want %h/0",
          c, controlWord, bus_error, mk);
      end
      step();
    end
    #1;
    n_cmp++;
    if (bus_error !== 1'b1 || controlWord !== 29'h0) begin
      n_bad++;
      $display("FAIL abort_pulse: got %b/%h want 1/0",
        bus_error, controlWord);
    end
    step();
    n_cmp++;
    if (state !== 2'd0 || bus_error !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_after: got %0d/%b want 0/0",
        state, bus_error);
    end
    bus.mem_ready = 1'b1;
    ns[2] = 2'd0;
    step();
  endtask

  task automatic test_illegal();
    instruction = 32'h0;
    rand_dec();
    #1;
    n_cmp++;
    if (illegal !== 1'b1 || controlWord !== NOP || K !== 64'h0) begin
      n_bad++;
      $display("FAIL ill_out: got %b/%h/%h want 1/%h/0",
        illegal, controlWord, K, NOP);
    end
    step();
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL ill_state: got %0d want 0", state);
    end
    instruction = RADD;
    ns[0] = 2'd0;
    #1;
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_clear: got %b want 0", illegal);
    end
    step();
  endtask

  task automatic test_wrap();
    instruction = RADD;
    rand_dec();
    for (int s = 1; s <= 3; s++) begin
      ns[0] = 2'(s);
      step();
    end
    n_cmp++;
    if (state !== 2'd3) begin
      n_bad++;
      $display("FAIL wrap_s3: got %0d want 3", state);
    end
    ns[0] = 2'd1;
    #1;
    n_cmp++;
    if (illegal !== 1'b1 || controlWord !== cw[0]) begin
      n_bad++;
      $display("FAIL wrap_ill: got %b/%h want 1/%h",
        illegal, controlWord, cw[0]);
    end
    step();
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_s0: got %0d want 0", state);
    end
  endtask

  task automatic test_reset_mid();
    instruction = mem_instr();
    rand_dec();
    cw[2][5] = 1'b1;
    ns[2] = 2'd1;
    bus.mem_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_flags: got %b%b want 00",
        bus.mem_req, bus_error);
    end
    step();
    reset = 1'b0;
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL rmid_stall: got %0d want 0", state);
    end
`ifdef PERF_CNT_EN
    n_cmp++;
    if (stall_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rmid_cnt: got %0d/%0d want 0/0",
        stall_cnt, retired_cnt);
    end
`endif
    bus.mem_ready = 1'b1;
    instruction = RADD;
    ns[0] = 2'd1;
    step();
    ns[0] = 2'd2;
    step();
    n_cmp++;
    if (state !== 2'd2) begin
      n_bad++;
      $display("FAIL rmid_s2: got %0d want 2", state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state !== 2'd0 || cur_instr !== RADD) begin
      n_bad++;
      $display("FAIL rmid_s2rst: got %0d/%h want 0/%h",
        state, cur_instr, RADD);
    end
  endtask

  task automatic test_random();
    logic [1:0]  m_state, n_state;
    logic [31:0] m_ir, ci;
    int          m_wait, cls;
    logic [28:0] e_cw, e_out;
    logic [63:0] e_k;
    logic [1:0]  e_ns;
    logic        e_bad, acc, e_req, e_ill, e_berr, chk_k;
    m_state = 2'd0;
    m_ir = 32'h0;
    m_wait = 0;
    for (int t = 0; t < 400; t++) begin
      reset = (t == 0) || ($urandom_range(0, 49) == 0);
      instruction = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      for (int i = 0; i < 4; i++) begin
        cw[i] = 29'($urandom);
        ns[i] = 2'($urandom);
        kk[i] = {$urandom, $urandom};
      end
      bus.mem_ready = ($urandom_range(0, 9) < 6);
      ci = (m_state == 2'd0) ? instruction : m_ir;
      cls = classify(ci);
      if (cls < 0) begin
        e_cw = NOP;
        e_k = 64'h0;
        e_ns = 2'd0;
        e_bad = 1'b1;
      end else begin
        e_cw = cw[cls];
        e_k = kk[cls];
        e_ns = ns[cls];
        e_bad = 1'b0;
      end
      acc = e_cw[5] || (e_cw[4:3] == 2'b10);
      e_req = acc && !reset;
      e_out = e_cw;
      e_ill = 1'b0;
      e_berr = 1'b0;
      chk_k = 1'b1;
      if (reset) begin
        n_state = 2'd0;
      end else if (acc && !bus.mem_ready && m_wait >= MW) begin
        e_out = 29'h0;
        e_berr = 1'b1;
        chk_k = 1'b0;
        n_state = 2'd0;
      end else if (acc && !bus.mem_ready) begin
        e_out[28:27] = 2'b00;
        e_out[6] = 1'b0;
        n_state = m_state;
      end else begin
        n_state = e_ns;
        e_ill = e_bad;
        if (m_state == 2'd3 && e_ns != 2'd0) begin
          n_state = 2'd0;
          e_ill = 1'b1;
        end
      end
      #1;
      n_cmp++;
      if (state !== m_state || cur_instr !== ci) begin
        n_bad++;
        $display("FAIL rnd_st t=%0d: got %0d/%h want %0d/%h",
          t, state, cur_instr, m_state, ci);
      end
      n_cmp++;
      if (controlWord !== e_out) begin
        n_bad++;
        $display("FAIL rnd_cw t=%0d: got %h want %h",
          t, controlWord, e_out);
      end
      if (chk_k) begin
        n_cmp++;
        if (K !== e_k) begin
          n_bad++;
          $display("FAIL rnd_k t=%0d: got %h want %h", t, K, e_k);
        end
      end
      n_cmp++;
      if ({bus.mem_req, illegal, bus_error}
          !== {e_req, e_ill, e_berr}) begin
        n_bad++;
        $display("FAIL rnd_flags t=%0d: got %b want %b", t,
          {bus.mem_req, illegal, bus_error}, {e_req, e_ill, e_berr});
      end
      if (reset) begin
        m_ir = 32'h0;
        m_wait = 0;
      end else begin
        if (acc && !bus.mem_ready && m_wait < MW) begin
          m_wait = m_wait + 1;
        end else begin
          if (m_state == 2'd0) m_ir = instruction;
          m_wait = 0;
        end
      end
      m_state = n_state;
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_radd();
    test_multistate();
    test_stall();
    test_abort();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
